// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with wait-state DTAck generation
// Optional release timeout with Bus_Error pulse: define BUS_ARB_TIMEOUT_EN
module bus_arbiter #(
  parameter int WAIT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        M0_AS_L,
  input  logic        M0_WE_L,
  input  logic [31:0] M0_Address,
  input  logic [3:0]  M0_Byte_Enable,
  input  logic [31:0] M0_Data_Out,
  output logic [31:0] M0_Data_In,
  output logic        M0_DTAck,
  input  logic        M1_AS_L,
  input  logic        M1_WE_L,
  input  logic [31:0] M1_Address,
  input  logic [3:0]  M1_Byte_Enable,
  input  logic [31:0] M1_Data_Out,
  output logic [31:0] M1_Data_In,
  output logic        M1_DTAck,
  output logic        AS_L,
  output logic        WE_L,
  output logic [31:0] Address,
  output logic [3:0]  Byte_Enable,
  output logic [31:0] Data_Out,
  input  logic [31:0] Data_In,
  output logic [1:0]  Grant,
  output logic        Bus_Error
);

  // One counter serves both the wait-state count and the release timeout
  localparam int CNT_MAX = (TIMEOUT_CYCLES > WAIT_CYCLES) ? TIMEOUT_CYCLES : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;        // 1 = M1 was granted last
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m0_dtack_q, m0_dtack_d;
  logic             m1_dtack_q, m1_dtack_d;
  logic             bus_error_q, bus_error_d;
  logic [1:0]       stale_q, stale_d;      // per-master: ignore requests until AS_L seen high
  logic             req0, req1, gnt_as_l;

  assign req0     = ~M0_AS_L & ~stale_q[0];
  assign req1     = ~M1_AS_L & ~stale_q[1];
  assign gnt_as_l = grant_q[1] ? M1_AS_L : M0_AS_L;

  assign Grant     = grant_q;
  assign M0_DTAck  = m0_dtack_q;
  assign M1_DTAck  = m1_dtack_q;
  assign Bus_Error = bus_error_q;

  // Next-state logic: round-robin grant, wait-state count, release handshake
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    m0_dtack_d  = 1'b0;
    m1_dtack_d  = 1'b0;
    bus_error_d = 1'b0;
    stale_d     = stale_q & {~M1_AS_L, ~M0_AS_L};
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          grant_d = 2'b01;
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = ACCESS;
        end else if (req1) begin
          grant_d = 2'b10;
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (gnt_as_l) begin
          // Abort: master withdrew its strobe, no acknowledge
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q == WAIT_LAST) begin
          m0_dtack_d = grant_q[0];
          m1_dtack_d = grant_q[1];
          state_d    = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (gnt_as_l) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          bus_error_d = 1'b1;
          stale_d     = stale_d | grant_q;
          grant_d     = 2'b00;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset favours M0 on first contention
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      m0_dtack_q  <= 1'b0;
      m1_dtack_q  <= 1'b0;
      bus_error_q <= 1'b0;
      stale_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      m0_dtack_q  <= m0_dtack_d;
      m1_dtack_q  <= m1_dtack_d;
      bus_error_q <= bus_error_d;
      stale_q     <= stale_d;
    end
  end

  // Slave-side and read-data mux: granted master is visible only in ACCESS/ACK
  always_comb begin
    AS_L        = 1'b1;
    WE_L        = 1'b1;
    Address     = '0;
    Byte_Enable = '0;
    Data_Out    = '0;
    M0_Data_In  = '0;
    M1_Data_In  = '0;
    if (state_q == ACCESS || state_q == ACK) begin
      if (grant_q[0]) begin
        AS_L        = M0_AS_L;
        WE_L        = M0_WE_L;
        Address     = M0_Address;
        Byte_Enable = M0_Byte_Enable;
        Data_Out    = M0_Data_Out;
      end else if (grant_q[1]) begin
        AS_L        = M1_AS_L;
        WE_L        = M1_WE_L;
        Address     = M1_Address;
        Byte_Enable = M1_Byte_Enable;
        Data_Out    = M1_Data_Out;
      end
    end
    if (state_q == ACK) begin
      if (grant_q[0]) begin
        M0_Data_In = Data_In;
      end else if (grant_q[1]) begin
        M1_Data_In = Data_In;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector bench for bus_arbiter
module tb_bus_arbiter;

  localparam logic [31:0] M0_ADDR = 32'h0000_0010;
  localparam logic [3:0]  M0_BE   = 4'b1111;
  localparam logic [31:0] M0_DOUT = 32'hA5A5_0F0F;
  localparam logic [31:0] M1_ADDR = 32'h0000_0800;
  localparam logic [3:0]  M1_BE   = 4'b0011;
  localparam logic [31:0] M1_DOUT = 32'h1234_5678;
  localparam logic [31:0] SLV_DIN = 32'hDEAD_BEEF;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic        M0_AS_L, M0_WE_L, M1_AS_L, M1_WE_L;
  logic [31:0] M0_Address, M0_Data_Out, M1_Address, M1_Data_Out;
  logic [3:0]  M0_Byte_Enable, M1_Byte_Enable;
  logic [31:0] M0_Data_In, M1_Data_In;
  logic        M0_DTAck, M1_DTAck;
  logic        AS_L, WE_L;
  logic [31:0] Address, Data_Out, Data_In;
  logic [3:0]  Byte_Enable;
  logic [1:0]  Grant;
  logic        Bus_Error;

  int tests_run = 0;
  int tests_failed = 0;

  bus_arbiter #(.WAIT_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .Clock(Clock), .Reset_L(Reset_L),
    .M0_AS_L(M0_AS_L), .M0_WE_L(M0_WE_L), .M0_Address(M0_Address),
    .M0_Byte_Enable(M0_Byte_Enable), .M0_Data_Out(M0_Data_Out),
    .M0_Data_In(M0_Data_In), .M0_DTAck(M0_DTAck),
    .M1_AS_L(M1_AS_L), .M1_WE_L(M1_WE_L), .M1_Address(M1_Address),
    .M1_Byte_Enable(M1_Byte_Enable), .M1_Data_Out(M1_Data_Out),
    .M1_Data_In(M1_Data_In), .M1_DTAck(M1_DTAck),
    .AS_L(AS_L), .WE_L(WE_L), .Address(Address), .Byte_Enable(Byte_Enable),
    .Data_Out(Data_Out), .Data_In(Data_In), .Grant(Grant), .Bus_Error(Bus_Error)
  );

  always #5 Clock = ~Clock;

  // drv: which master's address/BE/data appear on the slave side (0 none, 1 M0, 2 M1)
  // ack: which master sees DTAck and the slave read data (0 none, 1 M0, 2 M1)
  typedef struct {
    logic       m0_as_l, m0_we_l, m1_as_l, m1_we_l;
    logic [1:0] grant;
    logic       s_as_l, s_we_l;
    int         drv, ack;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t v(input logic a0, input logic w0, input logic a1, input logic w1,
                             input logic [1:0] g, input logic sa, input logic sw,
                             input int drv, input int ack);
    vec_t r;
    r.m0_as_l = a0; r.m0_we_l = w0; r.m1_as_l = a1; r.m1_we_l = w1;
    r.grant = g; r.s_as_l = sa; r.s_we_l = sw; r.drv = drv; r.ack = ack;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] exp_addr;
  logic [35:0] exp_bd;
  logic [32:0] exp_m0, exp_m1;
  logic [1:0]  seq[$];
  logic [1:0]  prev_g;
  logic        hold0, hold1;
  int          wait_n;

  initial begin
    // M0 read at 0x10
    vecs[0]  = v(0,1,1,1, 2'b00, 1,1, 0,0);
    vecs[1]  = v(0,1,1,1, 2'b01, 0,1, 1,0);
    vecs[2]  = v(0,1,1,1, 2'b01, 0,1, 1,0);
    vecs[3]  = v(0,1,1,1, 2'b01, 0,1, 1,1);
    vecs[4]  = v(1,1,1,1, 2'b01, 1,1, 0,0);
    vecs[5]  = v(1,1,1,1, 2'b00, 1,1, 0,0);
    // M1 write 0x12345678 to 0x800, BE 0011
    vecs[6]  = v(1,1,0,0, 2'b00, 1,1, 0,0);
    vecs[7]  = v(1,1,0,0, 2'b10, 0,0, 2,0);
    vecs[8]  = v(1,1,0,0, 2'b10, 0,0, 2,0);
    vecs[9]  = v(1,1,0,0, 2'b10, 0,0, 2,2);
    vecs[10] = v(1,1,1,1, 2'b10, 1,1, 0,0);
    vecs[11] = v(1,1,1,1, 2'b00, 1,1, 0,0);
    // M0 aborts in first ACCESS cycle: strobe drops same cycle, no DTAck
    vecs[12] = v(0,1,1,1, 2'b00, 1,1, 0,0);
    vecs[13] = v(1,1,1,1, 2'b01, 1,1, 1,0);
    vecs[14] = v(1,1,1,1, 2'b01, 1,1, 0,0);
    vecs[15] = v(1,1,1,1, 2'b00, 1,1, 0,0);
    // Both request, M0 was last -> M1 wins; M0 waits holding AS_L low
    vecs[16] = v(0,1,0,1, 2'b00, 1,1, 0,0);
    vecs[17] = v(0,1,0,1, 2'b10, 0,1, 2,0);
    vecs[18] = v(0,1,0,1, 2'b10, 0,1, 2,0);
    vecs[19] = v(0,1,0,1, 2'b10, 0,1, 2,2);
    vecs[20] = v(0,1,1,1, 2'b10, 1,1, 0,0);
    vecs[21] = v(0,1,1,1, 2'b00, 1,1, 0,0);
    vecs[22] = v(0,1,1,1, 2'b01, 0,1, 1,0);

    Reset_L = 1'b0;
    M0_AS_L = 1'b1; M0_WE_L = 1'b1; M1_AS_L = 1'b1; M1_WE_L = 1'b1;
    M0_Address = M0_ADDR; M0_Byte_Enable = M0_BE; M0_Data_Out = M0_DOUT;
    M1_Address = M1_ADDR; M1_Byte_Enable = M1_BE; M1_Data_Out = M1_DOUT;
    Data_In = SLV_DIN;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("reset grant", 64'(Grant), 64'(2'b00));
    chk("reset ctrl", 64'({AS_L, WE_L, M0_DTAck, M1_DTAck, Bus_Error}), 64'(5'b11000));
    chk("reset addr", 64'(Address), 64'h0);
    Reset_L = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge Clock);
      #1;
      M0_AS_L = vecs[i].m0_as_l; M0_WE_L = vecs[i].m0_we_l;
      M1_AS_L = vecs[i].m1_as_l; M1_WE_L = vecs[i].m1_we_l;
      @(negedge Clock);
      exp_addr = (vecs[i].drv == 1) ? M0_ADDR : (vecs[i].drv == 2) ? M1_ADDR : 32'h0;
      exp_bd   = (vecs[i].drv == 1) ? {M0_BE, M0_DOUT} : (vecs[i].drv == 2) ? {M1_BE, M1_DOUT} : 36'h0;
      exp_m0   = (vecs[i].ack == 1) ? {1'b1, SLV_DIN} : 33'h0;
      exp_m1   = (vecs[i].ack == 2) ? {1'b1, SLV_DIN} : 33'h0;
      chk($sformatf("v%0d grant", i), 64'(Grant), 64'(vecs[i].grant));
      chk($sformatf("v%0d as_we", i), 64'({AS_L, WE_L}), 64'({vecs[i].s_as_l, vecs[i].s_we_l}));
      chk($sformatf("v%0d addr", i), 64'(Address), 64'(exp_addr));
      chk($sformatf("v%0d be_dout", i), 64'({Byte_Enable, Data_Out}), 64'(exp_bd));
      chk($sformatf("v%0d m0_ack_din", i), 64'({M0_DTAck, M0_Data_In}), 64'(exp_m0));
      chk($sformatf("v%0d m1_ack_din", i), 64'({M1_DTAck, M1_Data_In}), 64'(exp_m1));
    end

    // Asynchronous reset mid-ACCESS: outputs return to idle with no clock edge
    #2;
    Reset_L = 1'b0;
    #1;
    chk("async grant", 64'(Grant), 64'(2'b00));
    chk("async ctrl", 64'({AS_L, WE_L, M0_DTAck, M1_DTAck}), 64'(4'b1100));
    chk("async addr", 64'(Address), 64'h0);
    chk("async be_dout", 64'({Byte_Enable, Data_Out}), 64'h0);
    M0_AS_L = 1'b0; M1_AS_L = 1'b0; M0_WE_L = 1'b1; M1_WE_L = 1'b1;
    @(negedge Clock);
    Reset_L = 1'b1;
    @(negedge Clock);
    chk("post-reset first grant", 64'(Grant), 64'(2'b01));

    // Continuous contention: each master drops its strobe after DTAck until the bus idles
    prev_g = Grant;
    seq.push_back(prev_g);
    hold0 = 1'b0; hold1 = 1'b0;
    for (int c = 0; c < 200 && seq.size() < 5; c++) begin
      if (M0_DTAck) begin M0_AS_L = 1'b1; hold0 = 1'b1; end
      else if (hold0 && Grant == 2'b00) begin M0_AS_L = 1'b0; hold0 = 1'b0; end
      if (M1_DTAck) begin M1_AS_L = 1'b1; hold1 = 1'b1; end
      else if (hold1 && Grant == 2'b00) begin M1_AS_L = 1'b0; hold1 = 1'b0; end
      @(negedge Clock);
      if (Grant != prev_g) begin
        prev_g = Grant;
        seq.push_back(Grant);
      end
    end
    chk("contention grant changes", 64'(seq.size()), 64'd5);
    if (seq.size() >= 5) begin
      chk("alt g0", 64'(seq[0]), 64'(2'b01));
      chk("alt g1", 64'(seq[1]), 64'(2'b00));
      chk("alt g2", 64'(seq[2]), 64'(2'b10));
      chk("alt g3", 64'(seq[3]), 64'(2'b00));
      chk("alt g4", 64'(seq[4]), 64'(2'b01));
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // M0 never releases after DTAck; M1 waits behind it
    Reset_L = 1'b0;
    M0_AS_L = 1'b1; M1_AS_L = 1'b1;
    @(negedge Clock);
    Reset_L = 1'b1;
    M0_AS_L = 1'b0; M1_AS_L = 1'b0;
    wait_n = 0;
    while (!M0_DTAck && wait_n < 20) begin @(negedge Clock); wait_n++; end
    chk("timeout dtack seen", 64'(M0_DTAck), 64'd1);
    wait_n = 0;
    while (!Bus_Error && wait_n < 40) begin @(negedge Clock); wait_n++; end
    chk("timeout bus_error delay", 64'(wait_n), 64'd17);
    chk("timeout grant", 64'(Grant), 64'(2'b00));
    @(negedge Clock);
    chk("timeout pulse width", 64'(Bus_Error), 64'd0);
    chk("timeout m1 granted", 64'(Grant), 64'(2'b10));
`else
    chk("bus_error tied low", 64'(Bus_Error), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter for the shared SRAM/IO/graphics slave bus.
- Master 0 is the CPU; master 1 is a secondary bus master, e.g. a graphics/DMA engine.
- The block grants the bus round-robin, multiplexes the winning master's address, control and data onto the slave side, and generates DTAck after a programmable number of wait states.
- It replaces the hard-wired DTAck on the CPU.

Parameters:
- WAIT_CYCLES, 2, cycles the slave strobe is held before DTAck (min 1; covers synchronous RAM read latency).
- TIMEOUT_CYCLES, 16, release-timeout limit in cycles (used only with the optional feature).

Ports:
- Clock  input  1  system clock
- Reset_L  input  1  asynchronous active-low reset
- M0_AS_L  input  1  master 0 address strobe, low = request
- M0_WE_L  input  1  master 0 write enable, low = write
- M0_Address  input  32  master 0 address
- M0_Byte_Enable  input  4  master 0 byte lanes
- M0_Data_Out  input  32  master 0 write data
- M0_Data_In  output  32  read data to master 0
- M0_DTAck  output  1  transfer acknowledge to master 0
- M1_AS_L, M1_WE_L, M1_Address, M1_Byte_Enable, M1_Data_Out, M1_Data_In, M1_DTAck  same as the M0 set, for master 1
- AS_L  output  1  slave-side address strobe
- WE_L  output  1  slave-side write enable
- Address  output  32  slave-side address
- Byte_Enable  output  4  slave-side byte lanes
- Data_Out  output  32  slave-side write data
- Data_In  input  32  read data from the slave data-bus multiplexer
- Grant  output  2  one-hot current owner (bit0 = M0, bit1 = M1)
- Bus_Error  output  1  release-timeout pulse (optional feature)

Behaviour:
- Reset (async, immediate):
  - state = IDLE, Grant = 00, AS_L = 1, WE_L = 1.
  - Address, Byte_Enable and Data_Out = 0.
  - M0_DTAck, M1_DTAck and Bus_Error = 0.
  - last_grant = M1, so M0 wins the first contention.
- States: IDLE, ACCESS, ACK, RELEASE.
- IDLE:
  - Sample M0_AS_L and M1_AS_L each cycle.
  - One requester: grant it.
  - Both requesting: grant the master that is not last_grant.
  - On grant: update last_grant and Grant, go to ACCESS with wait counter = 0.
- ACCESS:
  - Slave-side AS_L, WE_L, Address, Byte_Enable and Data_Out pass the granted master's signals combinationally.
  - Counter increments each cycle; when it reaches WAIT_CYCLES-1, go to ACK.
  - Slave strobe is therefore low for exactly WAIT_CYCLES cycles before ACK.
- ACK (exactly one cycle):
  - Granted master's DTAck = 1; slave-side signals still driven.
  - Granted master's Data_In = slave Data_In, valid this cycle.
  - Go to RELEASE.
- RELEASE:
  - Slave AS_L = 1, WE_L = 1; DTAck = 0; Grant held.
  - When the granted master's AS_L is high, go to IDLE next cycle with Grant = 00.
- Latency: AS_L sampled low in IDLE at cycle 0 → slave strobe cycles 1..WAIT_CYCLES → DTAck at cycle WAIT_CYCLES+1.
- Back-to-back: at least one IDLE cycle between transfers. Alternation between both masters is guaranteed under continuous contention.
- Abort: granted master raises AS_L during ACCESS → go to RELEASE, no DTAck is issued, and the slave strobe drops the same cycle.
- Non-granted master:
  - DTAck = 0 and Data_In = 0 at all times.
  - Its strobe is ignored until it is granted; it may hold AS_L low indefinitely while waiting.
- Outside ACCESS/ACK: slave AS_L = 1, WE_L = 1, Address / Byte_Enable / Data_Out = 0.
- Writes: slave WE_L is low for every ACCESS and ACK cycle. Slaves must tolerate the repeated, same-data write strobe.
- Registered signals: Grant, DTAck and state are registered; the data/address path is combinational via the Grant mux.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs in RELEASE.
  - If the granted master's AS_L is still low after TIMEOUT_CYCLES cycles, Bus_Error pulses high for one cycle and the state is forced to IDLE with Grant = 00.
  - That master's stale flag is set; its requests are ignored until its AS_L is sampled high, which clears the flag.
- Disabled: RELEASE waits indefinitely and Bus_Error is constant 0.

Test Plan:
- M0 read 0x00000010, WAIT_CYCLES = 2, slave Data_In = 0xDEADBEEF:
  - Slave AS_L low for cycles 1-3; M0_DTAck = 1 only in cycle 3.
  - M0_Data_In = 0xDEADBEEF in cycle 3; Grant = 01 throughout.
- M0 and M1 assert AS_L in the same cycle after reset:
  - M0 is granted first; M1 is granted after M0 releases (Grant 01 → 00 → 10).
  - Both hold continuous requests → grants alternate 01, 10, 01.
- M1 write 0x12345678, Byte_Enable = 0011, to 0x00000800:
  - Slave WE_L = 0, Address = 0x800, Data_Out = 0x12345678, Byte_Enable = 0011 during ACCESS/ACK.
  - M0 outputs stay at 0 throughout.
- M0 raises AS_L in the first ACCESS cycle:
  - No DTAck is issued; slave AS_L goes high the same cycle.
  - Grant returns to 00 within 2 cycles.
- Reset_L pulled low mid-ACCESS:
  - All outputs return to reset values immediately (asynchronously).
  - After release, simultaneous requests grant M0 first.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, M0 holds AS_L low after DTAck:
  - Bus_Error pulses once, 16 cycles into RELEASE; Grant = 00.
  - A pending M1 request is granted while M0 stays low.
